// File: rtl/piso_bit_feeder_pkg.sv
// Shared definitions for the PISO bit feeder: FSM state encoding and a
// width helper used to size the bit counter.
package piso_bit_feeder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bits needed to hold values 0..n-1; never returns less than 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry hold register in front of the shifter. It catches a word
// offered while the shifter is busy so the next word can start without a gap.
module piso_hold_buf
   import piso_bit_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] hb,
   output logic             hold_full,
   output logic             ready
);

   // Data and full flag; clear wins, load and pop never coincide since
   // load needs an empty entry and pop needs a full one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hb        <= '0;
         hold_full <= 1'b0;
      end else if (clear) begin
         hold_full <= 1'b0;
      end else if (pop) begin
         hold_full <= 1'b0;
      end else if (load) begin
         hb        <= din;
         hold_full <= 1'b1;
      end
   end

   // Ready depends on the register only, never on the incoming valid.
   assign ready = !hold_full;

endmodule

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder: turns WIDTH-bit words into a one-bit-per-
// cycle stream qualified by bit_valid, with a one-word hold buffer so
// back-to-back words stream without bubbles.
module piso_bit_feeder
   import piso_bit_feeder_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             flush,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned CW = clog2(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hb;
   logic             hold_full;
   logic             hb_ready;
   logic             xfer;
   logic             last;
   logic             hb_load;
   logic             hb_pop;

   assign last = (cnt == LastCnt);

   // A handshake only counts when flush is not also asserted.
   assign xfer = din_valid && hb_ready && !flush;

   // Words arriving mid-word park in the hold buffer; on the last bit the
   // held word takes priority over a direct load (it cannot coexist anyway).
   assign hb_load = xfer && (state == SHIFT) && !last;
   assign hb_pop  = !flush && (state == SHIFT) && last && hold_full;

   piso_hold_buf #(
      .WIDTH (WIDTH)
   ) u_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (hb_load),
      .pop       (hb_pop),
      .din       (din),
      .hb        (hb),
      .hold_full (hold_full),
      .ready     (hb_ready)
   );

   // FSM, shifter and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xfer) begin
                  sr    <= din;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!last) begin
                  if (MSB_FIRST) begin
                     sr <= {sr[WIDTH-2:0], 1'b0};
                  end else begin
                     sr <= {1'b0, sr[WIDTH-1:1]};
                  end
                  cnt <= cnt + CW'(1);
               end else if (hold_full) begin
                  sr  <= hb;
                  cnt <= '0;
               end else if (xfer) begin
                  sr  <= din;
                  cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode straight from registers, so async reset clears them at once.
   always_comb begin
      bit_valid   = (state == SHIFT);
      bit_out     = bit_valid && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
      frame_start = bit_valid && (cnt == '0);
      busy        = bit_valid || hold_full;
      din_ready   = hb_ready;
   end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Directed bench for piso_bit_feeder: one MSB-first and one LSB-first instance.
module tb_piso_bit_feeder;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       flush;
   logic       bit_out;
   logic       bit_valid;
   logic       frame_start;
   logic       busy;

   logic [7:0] din_l;
   logic       din_valid_l;
   logic       din_ready_l;
   logic       flush_l;
   logic       bit_out_l;
   logic       bit_valid_l;
   logic       frame_start_l;
   logic       busy_l;

   logic       use_l;
   logic       s_bo;
   logic       s_bv;
   logic       s_fs;

   int errors;
   int checks;

   piso_bit_feeder #(
      .WIDTH     (8),
      .MSB_FIRST (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .flush       (flush),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .busy        (busy)
   );

   piso_bit_feeder #(
      .WIDTH     (8),
      .MSB_FIRST (1'b0)
   ) dut_l (
      .clk         (clk),
      .rst         (rst),
      .din         (din_l),
      .din_valid   (din_valid_l),
      .din_ready   (din_ready_l),
      .flush       (flush_l),
      .bit_out     (bit_out_l),
      .bit_valid   (bit_valid_l),
      .frame_start (frame_start_l),
      .busy        (busy_l)
   );

   assign s_bo = use_l ? bit_out_l     : bit_out;
   assign s_bv = use_l ? bit_valid_l   : bit_valid;
   assign s_fs = use_l ? frame_start_l : frame_start;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; samples are taken 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Record 8 cycles of the selected instance: bits first-out in the MSB of seq.
   task automatic collect8(output logic [7:0] seq, output logic [7:0] vpat,
                           output logic [7:0] fpat);
      seq  = '0;
      vpat = '0;
      fpat = '0;
      for (int i = 0; i < 8; i++) begin
         seq  = {seq[6:0], s_bo};
         vpat = {vpat[6:0], s_bv};
         fpat = {fpat[6:0], s_fs};
         step();
      end
   endtask

   logic [7:0]  seq;
   logic [7:0]  vpat;
   logic [7:0]  fpat;
   logic [15:0] seq16;
   logic [15:0] vpat16;
   logic [15:0] fpat16;
   logic [15:0] rdy16;
   logic [23:0] stream;
   logic [27:0] vmask;
   logic [7:0]  words [3];
   int          accedge [3];
   int          k;
   logic        acc;
   int          stray;

   initial begin
      errors      = 0;
      checks      = 0;
      use_l       = 1'b0;
      rst         = 1'b0;
      din         = '0;
      din_valid   = 1'b0;
      flush       = 1'b0;
      din_l       = '0;
      din_valid_l = 1'b0;
      flush_l     = 1'b0;

      // Reset state
      #1;
      check("rst_bit_valid", 32'(bit_valid), 32'd0);
      check("rst_bit_out", 32'(bit_out), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_din_ready", 32'(din_ready), 32'd1);
      step();
      step();
      rst = 1'b1;
      step();

      // Single word 0xD0, MSB first
      din       = 8'hD0;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      collect8(seq, vpat, fpat);
      check("single_bits", 32'(seq), 32'hD0);
      check("single_valid", 32'(vpat), 32'hFF);
      check("single_frame", 32'(fpat), 32'h80);
      check("single_end_valid", 32'(bit_valid), 32'd0);
      check("single_end_busy", 32'(busy), 32'd0);

      // Back-to-back 0xD0, 0xB4
      din       = 8'hD0;
      din_valid = 1'b1;
      step();
      seq16  = '0;
      vpat16 = '0;
      fpat16 = '0;
      rdy16  = '0;
      for (int i = 0; i < 16; i++) begin
         seq16  = {seq16[14:0], bit_out};
         vpat16 = {vpat16[14:0], bit_valid};
         fpat16 = {fpat16[14:0], frame_start};
         rdy16  = {rdy16[14:0], din_ready};
         if (i == 0) din = 8'hB4;
         if (i == 1) din_valid = 1'b0;
         step();
      end
      check("b2b_bits", 32'(seq16), 32'hD0B4);
      check("b2b_valid", 32'(vpat16), 32'hFFFF);
      check("b2b_frame", 32'(fpat16), 32'h8080);
      check("b2b_ready", 32'(rdy16), 32'h80FF);
      check("b2b_end_valid", 32'(bit_valid), 32'd0);

      // LSB first, 0x0B -> 1,1,0,1,0,0,0,0
      use_l       = 1'b1;
      din_l       = 8'h0B;
      din_valid_l = 1'b1;
      step();
      din_valid_l = 1'b0;
      collect8(seq, vpat, fpat);
      check("lsb_bits", 32'(seq), 32'hD0);
      check("lsb_frame", 32'(fpat), 32'h80);
      check("lsb_end_valid", 32'(bit_valid_l), 32'd0);
      use_l = 1'b0;

      // Backpressure: three words offered with din_valid held
      words[0] = 8'h01;
      words[1] = 8'h02;
      words[2] = 8'h03;
      k         = 0;
      stream    = '0;
      vmask     = '0;
      din       = words[0];
      din_valid = 1'b1;
      for (int c = 0; c < 28; c++) begin
         acc = din_valid && din_ready;
         step();
         if (acc) begin
            accedge[k] = c;
            k++;
            if (k < 3) din = words[k];
            else din_valid = 1'b0;
         end
         vmask[c] = bit_valid;
         if (bit_valid) stream = {stream[22:0], bit_out};
      end
      check("bp_accepts", 32'(k), 32'd3);
      check("bp_acc0", 32'(accedge[0]), 32'd0);
      check("bp_acc1", 32'(accedge[1]), 32'd1);
      check("bp_acc2", 32'(accedge[2]), 32'd9);
      check("bp_stream", 32'(stream), 32'h010203);
      check("bp_valid_mask", 32'(vmask), 32'h0FFFFFF);

      // Flush on bit index 3 with the hold buffer full
      din       = 8'hAA;
      din_valid = 1'b1;
      step();
      din = 8'h55;
      step();
      din_valid = 1'b0;
      check("fl_hold_ready", 32'(din_ready), 32'd0);
      step();
      step();
      check("fl_pre_valid", 32'(bit_valid), 32'd1);
      check("fl_pre_bit3", 32'(bit_out), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_valid", 32'(bit_valid), 32'd0);
      check("fl_busy", 32'(busy), 32'd0);
      check("fl_ready", 32'(din_ready), 32'd1);
      // Flush wins over a simultaneous handshake
      din       = 8'hFF;
      din_valid = 1'b1;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      din_valid = 1'b0;
      check("fl_prio_valid", 32'(bit_valid), 32'd0);
      check("fl_prio_busy", 32'(busy), 32'd0);
      din       = 8'h96;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      collect8(seq, vpat, fpat);
      check("fl_next_bits", 32'(seq), 32'h96);
      check("fl_next_frame", 32'(fpat), 32'h80);

      // Async reset in the middle of a word
      din       = 8'hF0;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step();
      #2;
      rst = 1'b0;
      #1;
      check("ar_valid", 32'(bit_valid), 32'd0);
      check("ar_frame", 32'(frame_start), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_ready", 32'(din_ready), 32'd1);
      check("ar_bit_out", 32'(bit_out), 32'd0);
      step();
      rst = 1'b1;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bit_valid || busy) stray++;
      end
      check("ar_no_resume", 32'(stray), 32'd0);
      din       = 8'h3C;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      collect8(seq, vpat, fpat);
      check("ar_next_bits", 32'(seq), 32'h3C);
      check("ar_next_valid", 32'(vpat), 32'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
